// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the direct-mapped write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WB_REQ,
    FILL_REQ,
    FILL_WAIT
  } dcache_state_t;

  typedef enum logic {
    WR_STORE,
    WR_FILL
  } dcache_wr_mode_t;

  localparam int unsigned MAX_ADDR_W = 64;
  typedef logic [MAX_ADDR_W-1:0] wide_addr_t;

  function automatic int unsigned offset_bits(input int unsigned line_size);
    return $clog2(line_size / 8);
  endfunction

  function automatic int unsigned index_bits(input int unsigned size, input int unsigned line_size);
    return $clog2(size / line_size);
  endfunction

  function automatic int unsigned tag_bits(input int unsigned addr_size, input int unsigned size,
                                           input int unsigned line_size);
    return addr_size - index_bits(size, line_size) - offset_bits(line_size);
  endfunction

  // Line-aligned byte address: {tag, index, zero offset}, caller truncates to its width.
  function automatic wide_addr_t line_addr(input wide_addr_t tag, input wide_addr_t index,
                                           input int unsigned idx_bits, input int unsigned off_bits);
    return (tag << (idx_bits + off_bits)) | (index << off_bits);
  endfunction

endpackage

// File: rtl/memory_interface.sv
// Line-wide request/response bus between the cache (master) and backing memory.
interface memory_interface #(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned LINE_SIZE = 32*8
) ();

  logic [ADDR_SIZE-1:0] addr;
  logic [LINE_SIZE-1:0] wr_data;
  logic [LINE_SIZE-1:0] rd_data;
  logic                 valid;
  logic                 write;
  logic                 ready;

  modport master (
    output addr, wr_data, valid, write,
    input  rd_data, ready
  );

  modport slave (
    input  addr, wr_data, valid, write,
    output rd_data, ready
  );

endinterface

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage: combinational read port, one write port that
// either merges store bytes into a word or installs a whole fetched line.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 128,
  parameter int unsigned INDEX_BITS = 7,
  parameter int unsigned TAG_BITS   = 20,
  parameter int unsigned LINE_SIZE  = 256,
  parameter int unsigned WORD_SIZE  = 32,
  parameter int unsigned WSEL_BITS  = 3
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic [INDEX_BITS-1:0]   rd_index_i,
  output logic [TAG_BITS-1:0]     rd_tag_o,
  output logic                    rd_valid_o,
  output logic                    rd_dirty_o,
  output logic [LINE_SIZE-1:0]    rd_line_o,
  input  logic                    wr_en_i,
  input  dcache_wr_mode_t         wr_mode_i,
  input  logic [INDEX_BITS-1:0]   wr_index_i,
  input  logic [WSEL_BITS-1:0]    wr_word_i,
  input  logic [WORD_SIZE/8-1:0]  wr_be_i,
  input  logic [WORD_SIZE-1:0]    wr_word_data_i,
  input  logic [TAG_BITS-1:0]     wr_tag_i,
  input  logic [LINE_SIZE-1:0]    wr_line_i
);

  localparam int unsigned BE_BITS = WORD_SIZE / 8;

  logic [LINE_SIZE-1:0] data_q [NUM_LINES];
  logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise
    // paths that skip an assignment infer a latch.
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (wr_en_i) begin
      if (wr_mode_i == WR_FILL) begin
        valid_d[wr_index_i] = 1'b1;
        dirty_d[wr_index_i] = 1'b0;
      end else begin
        dirty_d[wr_index_i] = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // NOTE: tag and data storage carry no reset; the valid bits gate every use of
  // them, and a reset would keep the arrays from mapping onto RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      if (wr_mode_i == WR_FILL) begin
        data_q[wr_index_i] <= wr_line_i;
        tag_q[wr_index_i]  <= wr_tag_i;
      end else begin
        for (int b = 0; b < BE_BITS; b++) begin
          if (wr_be_i[b]) begin
            data_q[wr_index_i][wr_word_i*WORD_SIZE + b*8 +: 8] <= wr_word_data_i[b*8 +: 8];
          end
        end
      end
    end
  end

  assign rd_tag_o   = tag_q[rd_index_i];
  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_dirty_o = dirty_q[rd_index_i];
  assign rd_line_o  = data_q[rd_index_i];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, write-back, write-allocate data cache: hit logic, miss FSM and
// line bus master. Optional hit/miss counters are enabled with DCACHE_STATS_EN.
module dcache
  import dcache_pkg::*;
#(
  parameter int unsigned SIZE      = 4*1024*8,
  parameter int unsigned LINE_SIZE = 32*8,
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned WORD_SIZE = 32
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    req_valid_i,
  input  logic                    req_write_i,
  input  logic [ADDR_SIZE-1:0]    req_addr_i,
  input  logic [WORD_SIZE-1:0]    req_wr_data_i,
  input  logic [WORD_SIZE/8-1:0]  req_wr_be_i,
  output logic                    req_ready_o,
  output logic [WORD_SIZE-1:0]    req_rd_data_o,
`ifdef DCACHE_STATS_EN
  output logic [31:0]             hit_count_o,
  output logic [31:0]             miss_count_o,
`endif
  memory_interface.master         memory_bus
);

  localparam int unsigned OFFSET_BITS = offset_bits(LINE_SIZE);
  localparam int unsigned INDEX_BITS  = index_bits(SIZE, LINE_SIZE);
  localparam int unsigned TAG_BITS    = tag_bits(ADDR_SIZE, SIZE, LINE_SIZE);
  localparam int unsigned NUM_LINES   = SIZE / LINE_SIZE;
  localparam int unsigned WSEL_BITS   = OFFSET_BITS - 2;

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_index;
  logic [WSEL_BITS-1:0]  req_word;

  assign req_tag   = req_addr_i[ADDR_SIZE-1 -: TAG_BITS];
  assign req_index = req_addr_i[OFFSET_BITS +: INDEX_BITS];
  assign req_word  = req_addr_i[2 +: WSEL_BITS];

  logic [TAG_BITS-1:0]  rd_tag;
  logic                 rd_valid;
  logic                 rd_dirty;
  logic [LINE_SIZE-1:0] rd_line;

  logic                  arr_wr_en;
  dcache_wr_mode_t       arr_wr_mode;
  logic [INDEX_BITS-1:0] arr_wr_index;

  dcache_state_t         state_q, state_d;
  logic                  bus_valid_q, bus_valid_d;
  logic                  bus_write_q, bus_write_d;
  logic [ADDR_SIZE-1:0]  bus_addr_q, bus_addr_d;
  logic [LINE_SIZE-1:0]  bus_wdata_q, bus_wdata_d;
  logic [TAG_BITS-1:0]   miss_tag_q, miss_tag_d;
  logic [INDEX_BITS-1:0] miss_index_q, miss_index_d;

  dcache_line_array #(
    .NUM_LINES  (NUM_LINES),
    .INDEX_BITS (INDEX_BITS),
    .TAG_BITS   (TAG_BITS),
    .LINE_SIZE  (LINE_SIZE),
    .WORD_SIZE  (WORD_SIZE),
    .WSEL_BITS  (WSEL_BITS)
  ) u_lines (
    .clk_i          (clk_i),
    .reset_ni       (reset_ni),
    .rd_index_i     (req_index),
    .rd_tag_o       (rd_tag),
    .rd_valid_o     (rd_valid),
    .rd_dirty_o     (rd_dirty),
    .rd_line_o      (rd_line),
    .wr_en_i        (arr_wr_en),
    .wr_mode_i      (arr_wr_mode),
    .wr_index_i     (arr_wr_index),
    .wr_word_i      (req_word),
    .wr_be_i        (req_wr_be_i),
    .wr_word_data_i (req_wr_data_i),
    .wr_tag_i       (miss_tag_q),
    .wr_line_i      (memory_bus.rd_data)
  );

  logic is_idle;
  logic hit;
  logic miss_start;

  assign is_idle    = (state_q == IDLE);
  assign hit        = rd_valid && (rd_tag == req_tag);
  assign miss_start = is_idle && req_valid_i && !hit;

  assign req_ready_o   = req_valid_i && is_idle && hit;
  assign req_rd_data_o = rd_line[req_word*WORD_SIZE +: WORD_SIZE];

  // Line addresses are built wide by the package helper, then trimmed to the bus width.
  wide_addr_t victim_addr_w, req_addr_w, miss_addr_w;

  assign victim_addr_w = line_addr(wide_addr_t'(rd_tag), wide_addr_t'(req_index), INDEX_BITS, OFFSET_BITS);
  assign req_addr_w    = line_addr(wide_addr_t'(req_tag), wide_addr_t'(req_index), INDEX_BITS, OFFSET_BITS);
  assign miss_addr_w   = line_addr(wide_addr_t'(miss_tag_q), wide_addr_t'(miss_index_q), INDEX_BITS, OFFSET_BITS);

  logic unused_bits;
  assign unused_bits = ^{req_addr_i[1:0], victim_addr_w[MAX_ADDR_W-1:ADDR_SIZE],
                         req_addr_w[MAX_ADDR_W-1:ADDR_SIZE], miss_addr_w[MAX_ADDR_W-1:ADDR_SIZE]};

  always_comb begin
    state_d      = state_q;
    bus_valid_d  = bus_valid_q;
    bus_write_d  = bus_write_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    miss_tag_d   = miss_tag_q;
    miss_index_d = miss_index_q;
    arr_wr_en    = 1'b0;
    arr_wr_mode  = WR_STORE;
    arr_wr_index = req_index;

    unique case (state_q)
      IDLE: begin
        if (req_valid_i && hit) begin
          arr_wr_en = req_write_i;
        end else if (req_valid_i) begin
          miss_tag_d   = req_tag;
          miss_index_d = req_index;
          bus_valid_d  = 1'b1;
          if (rd_valid && rd_dirty) begin
            state_d     = WB_REQ;
            bus_write_d = 1'b1;
            bus_addr_d  = victim_addr_w[ADDR_SIZE-1:0];
            bus_wdata_d = rd_line;
          end else begin
            state_d     = FILL_REQ;
            bus_write_d = 1'b0;
            bus_addr_d  = req_addr_w[ADDR_SIZE-1:0];
          end
        end
      end
      WB_REQ: begin
        // Victim accepted: valid stays high and the same request slot turns into the fill.
        if (memory_bus.ready) begin
          state_d     = FILL_REQ;
          bus_write_d = 1'b0;
          bus_addr_d  = miss_addr_w[ADDR_SIZE-1:0];
        end
      end
      FILL_REQ: begin
        if (memory_bus.ready) begin
          state_d     = FILL_WAIT;
          bus_valid_d = 1'b0;
        end
      end
      FILL_WAIT: begin
        arr_wr_index = miss_index_q;
        if (memory_bus.ready) begin
          arr_wr_en   = 1'b1;
          arr_wr_mode = WR_FILL;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      bus_valid_q  <= 1'b0;
      bus_write_q  <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      miss_tag_q   <= '0;
      miss_index_q <= '0;
    end else begin
      state_q      <= state_d;
      bus_valid_q  <= bus_valid_d;
      bus_write_q  <= bus_write_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      miss_tag_q   <= miss_tag_d;
      miss_index_q <= miss_index_d;
    end
  end

  assign memory_bus.valid   = bus_valid_q;
  assign memory_bus.write   = bus_write_q;
  assign memory_bus.addr    = bus_addr_q;
  assign memory_bus.wr_data = bus_wdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    hit_count_d  = hit_count_q + 32'(req_ready_o);
    miss_count_d = miss_count_q + 32'(miss_start);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count_o  = hit_count_q;
  assign miss_count_o = miss_count_q;
`else
  logic unused_miss_start;
  assign unused_miss_start = miss_start;
`endif

endmodule
